multicycle_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the KGP-RISC core. It steps each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB.
- Consumes the opCode/fCode fields and the decoded control bits from the combinational control unit. Turns them into one-cycle enables for PC, IR, ALU flags, data memory and register file.
- Owns the req/ack handshakes to instruction and data memory, plus a timeout trap.

---
 rtl/kgp_risc_pkg.sv | 31 +++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/multicycle_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP-RISC multi-cycle control path:
// sequencer state encodings, trap cause codes and major opcodes.
package kgp_risc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_IMM   = 4'b0001;
    localparam logic [3:0] OP_MEM   = 4'b0010;
    localparam logic [3:0] OP_BRREG = 4'b0011;
    localparam logic [3:0] OP_BR    = 4'b0100;

    // An opcode beyond the branch group, or a non-R-type opcode that asserts
    // no control bit at all, cannot be executed.
    function automatic logic is_illegal(input logic [3:0] op, input logic any_ctl);
        return (op > OP_BR) || (!any_ctl && (op != OP_RTYPE));
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter shared by the instruction and data memory handshakes; flags a
// timeout when a request has gone MEM_TIMEOUT cycles without an ack.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             req,
    input  logic             ack,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             timeout
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || ack) begin
            cnt_d = '0;
        end else if (req) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack in the final waiting cycle wins over the timeout.
    assign timeout  = req && !ack && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign wait_cnt = cnt_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// KGP-RISC multi-cycle sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and issues the one-cycle datapath strobes.
module multicycle_sequencer
    import kgp_risc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opCode,
    input  logic [3:0]  fCode,
    input  logic        memToReg,
    input  logic        memWrite,
    input  logic        regWrite,
    input  logic [1:0]  branch,
    input  logic        link,
    input  logic        branchTaken,
    input  logic        imemAck,
    input  logic        dmemAck,
    input  logic        haltReq,
    output logic        imemReq,
    output logic        irWrite,
    output logic        aluEn,
    output logic        flagWrite,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic        regWriteEn,
    output logic        linkWrite,
    output logic        pcWrite,
    output logic        pcSel,
    output logic        trap,
    output logic [1:0]  trapCause,
    output logic [31:0] instrCount,
    output logic [2:0]  state
);

    state_e      state_q, state_d;
    logic        mem_to_reg_q, mem_write_q, reg_write_q, link_q, is_mem_q, flag_op_q;
    logic [1:0]  branch_q;
    logic        pc_sel_q, pc_sel_exec;
    logic        trap_q;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] count_q;

    logic        imem_req, ir_write, alu_en, flag_write, dmem_req, dmem_we;
    logic        reg_write_en, link_write, pc_write, pc_sel;
    logic        retire, enter_trap;

    logic             timer_req, timer_ack, timer_clr, timeout;
    logic [CNT_W-1:0] wait_cnt;

    // The function field only matters to the ALU decoder.
    logic unused_inputs;
    assign unused_inputs = ^{fCode, wait_cnt};

    assign timer_req = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign timer_ack = (state_q == ST_FETCH) ? imemAck :
                       (state_q == ST_MEM)   ? dmemAck : 1'b0;
    assign timer_clr = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .req      (timer_req),
        .ack      (timer_ack),
        .wait_cnt (wait_cnt),
        .timeout  (timeout)
    );

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        alu_en       = 1'b0;
        flag_write   = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_write_en = 1'b0;
        link_write   = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        pc_sel_exec  = 1'b0;
        retire       = 1'b0;
        enter_trap   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!haltReq) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imemAck) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    enter_trap = 1'b1;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (is_illegal(opCode, |{memToReg, memWrite, regWrite, branch, link})) begin
                    enter_trap = 1'b1;
                    cause_d    = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_en      = 1'b1;
                flag_write  = flag_op_q;
                pc_sel_exec = (branch_q != 2'b00) && branchTaken;
                if (is_mem_q) begin
                    state_d = ST_MEM;
                end else if (reg_write_q || link_q) begin
                    state_d = ST_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write_q;
                if (dmemAck) begin
                    if (mem_to_reg_q) state_d = ST_WB;
                    else              retire  = 1'b1;
                end else if (timeout) begin
                    enter_trap = 1'b1;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_write_en = 1'b1;
                link_write   = link_q;
                retire       = 1'b1;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase

        if (enter_trap) begin
            state_d = ST_TRAP;
        end
        // The retiring state owns the single PC strobe for the instruction.
        if (retire) begin
            pc_write = 1'b1;
            pc_sel   = (state_q == ST_EXEC) ? pc_sel_exec : pc_sel_q;
            state_d  = haltReq ? ST_IDLE : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            branch_q     <= 2'b00;
            link_q       <= 1'b0;
            is_mem_q     <= 1'b0;
            flag_op_q    <= 1'b0;
            pc_sel_q     <= 1'b0;
            trap_q       <= 1'b0;
            cause_q      <= CAUSE_NONE;
            count_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                mem_to_reg_q <= memToReg;
                mem_write_q  <= memWrite;
                reg_write_q  <= regWrite;
                branch_q     <= branch;
                link_q       <= link;
                is_mem_q     <= (opCode == OP_MEM);
                flag_op_q    <= (opCode == OP_RTYPE) || (opCode == OP_IMM);
            end
            if (state_q == ST_EXEC) begin
                pc_sel_q <= pc_sel_exec;
            end
            if (enter_trap) begin
                trap_q  <= 1'b1;
                cause_q <= cause_d;
            end
            if (retire) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Strobes are masked while reset is held so an aborted access never
    // leaks a request or a PC/register-file write.
    assign imemReq    = rst & imem_req;
    assign irWrite    = rst & ir_write;
    assign aluEn      = rst & alu_en;
    assign flagWrite  = rst & flag_write;
    assign dmemReq    = rst & dmem_req;
    assign dmemWe     = rst & dmem_we;
    assign regWriteEn = rst & reg_write_en;
    assign linkWrite  = rst & link_write;
    assign pcWrite    = rst & pc_write;
    assign pcSel      = rst & pc_sel;
    assign trap       = trap_q;
    assign trapCause  = cause_q;
    assign instrCount = count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: directed and random instructions, each compared against
// a per-instruction model of cycle counts, strobe counts and trap outcome.
module tb_multicycle_sequencer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  opCode = '0, fCode = '0;
    logic        memToReg = 0, memWrite = 0, regWrite = 0, link = 0, branchTaken = 0;
    logic [1:0]  branch = '0;
    logic        imemAck = 0, dmemAck = 0, haltReq = 0;
    logic        imemReq, irWrite, aluEn, flagWrite, dmemReq, dmemWe;
    logic        regWriteEn, linkWrite, pcWrite, pcSel, trap;
    logic [1:0]  trapCause;
    logic [31:0] instrCount;
    logic [2:0]  state;

    int total = 0;
    int bad = 0;
    int exp_count = 0;
    int exp_first = 1;

    multicycle_sequencer #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .opCode(opCode), .fCode(fCode),
        .memToReg(memToReg), .memWrite(memWrite), .regWrite(regWrite),
        .branch(branch), .link(link), .branchTaken(branchTaken),
        .imemAck(imemAck), .dmemAck(dmemAck), .haltReq(haltReq),
        .imemReq(imemReq), .irWrite(irWrite), .aluEn(aluEn), .flagWrite(flagWrite),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .regWriteEn(regWriteEn),
        .linkWrite(linkWrite), .pcWrite(pcWrite), .pcSel(pcSel), .trap(trap),
        .trapCause(trapCause), .instrCount(instrCount), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset(input logic hold_halt);
        @(posedge clk); #1;
        rst = 1'b0; imemAck = 1'b0; dmemAck = 1'b0; haltReq = hold_halt;
        @(negedge clk);
        chk("rst_abort_strobes", {28'd0, imemReq, dmemReq, pcWrite, regWriteEn}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_trap", {trap, trapCause}, 0);
        chk("rst_count", instrCount, 0);
        chk("idle_outputs", {imemReq, irWrite, aluEn, flagWrite, dmemReq, dmemWe,
                             regWriteEn, linkWrite, pcWrite, pcSel}, 0);
        exp_count = 0;
        exp_first = 1;
        if (hold_halt) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("halt_holds_idle", state, 0);
            haltReq = 1'b0;
        end
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op,
                             input logic m2r, input logic mw, input logic rw,
                             input logic [1:0] br, input logic lk, input logic tk,
                             input int idel, input int ddel, input logic halt);
        bit ill, ism, wb, exec_r, ex_trap, done, trapped, first;
        int ex_cause, ex_cyc, ex_ireq, ex_dreq, ex_dwe;
        int c_cyc, c_ireq, c_irw, c_alu, c_flg, c_dreq, c_dwe, c_rwe, c_lwr, c_pcw, c_pcs;
        int fcnt, dcnt;
        c_cyc = 0; c_ireq = 0; c_irw = 0; c_alu = 0; c_flg = 0; c_dreq = 0;
        c_dwe = 0; c_rwe = 0; c_lwr = 0; c_pcw = 0; c_pcs = 0;
        fcnt = 0; dcnt = 0; done = 0; trapped = 0; first = 1;

        ill = (op > 4'd4) || ({m2r, mw, rw, br, lk} == 6'd0 && op != 4'd0);
        ism = (op == 4'd2);
        wb  = ism ? m2r : (rw | lk);
        exec_r = 0; ex_trap = 0; ex_cause = 0; ex_dreq = 0; ex_dwe = 0;
        if (idel >= T) begin
            ex_trap = 1; ex_cause = 1; ex_cyc = T; ex_ireq = T;
        end else begin
            ex_ireq = idel + 1;
            if (ill) begin
                ex_trap = 1; ex_cause = 2; ex_cyc = idel + 2;
            end else begin
                exec_r = 1;
                ex_cyc = idel + 3;
                if (ism) begin
                    if (ddel >= T) begin
                        ex_trap = 1; ex_cause = 1; ex_dreq = T;
                    end else begin
                        ex_dreq = ddel + 1;
                    end
                    ex_dwe = mw ? ex_dreq : 0;
                    ex_cyc += ex_dreq;
                end
                if (!ex_trap && wb) ex_cyc++;
            end
        end

        opCode = op; fCode = 4'($urandom); memToReg = m2r; memWrite = mw;
        regWrite = rw; branch = br; link = lk; branchTaken = tk;

        for (int s = 0; s < 100 && !done; s++) begin
            @(posedge clk); #1;
            imemAck = imemReq ? (fcnt == idel) : 1'($urandom_range(0, 1));
            if (imemReq) fcnt++;
            dmemAck = dmemReq ? (dcnt == ddel) : 1'($urandom_range(0, 1));
            if (dmemReq) dcnt++;
            @(negedge clk);
            if (first) begin
                chk({tag, "/start_state"}, state, exp_first);
                chk({tag, "/start_count"}, instrCount, exp_count);
                first = 0;
            end
            if (state == 3'd6) begin
                trapped = 1; done = 1;
            end else begin
                c_cyc++;
                c_ireq += int'(imemReq); c_irw += int'(irWrite); c_alu += int'(aluEn);
                c_flg += int'(flagWrite); c_dreq += int'(dmemReq); c_dwe += int'(dmemWe);
                c_rwe += int'(regWriteEn); c_lwr += int'(linkWrite);
                if (pcWrite) begin
                    c_pcw++; c_pcs = int'(pcSel); done = 1;
                end
                haltReq = halt;
            end
        end

        chk({tag, "/finished"}, 32'(done), 1);
        chk({tag, "/trapped"}, 32'(trapped), 32'(ex_trap));
        chk({tag, "/cycles"}, c_cyc, ex_cyc);
        chk({tag, "/imemReq"}, c_ireq, ex_ireq);
        chk({tag, "/irWrite"}, c_irw, (idel < T) ? 1 : 0);
        chk({tag, "/aluEn"}, c_alu, 32'(exec_r));
        chk({tag, "/flagWrite"}, c_flg, (exec_r && op <= 4'd1) ? 1 : 0);
        chk({tag, "/dmemReq"}, c_dreq, ex_dreq);
        chk({tag, "/dmemWe"}, c_dwe, ex_dwe);
        chk({tag, "/regWriteEn"}, c_rwe, (!ex_trap && wb) ? 1 : 0);
        chk({tag, "/linkWrite"}, c_lwr, (!ex_trap && wb && lk) ? 1 : 0);
        chk({tag, "/pcWrite"}, c_pcw, ex_trap ? 0 : 1);
        chk({tag, "/pcSel"}, c_pcs, (!ex_trap && br != 2'b00 && tk) ? 1 : 0);

        if (ex_trap) begin
            chk({tag, "/trap"}, 32'(trap), 1);
            chk({tag, "/trapCause"}, 32'(trapCause), ex_cause);
            haltReq = 1'b1;
            for (int s = 0; s < 3; s++) begin
                @(posedge clk); #1;
                imemAck = 1'($urandom); dmemAck = 1'($urandom);
                @(negedge clk);
            end
            chk({tag, "/trap_sticky"}, {29'd0, trap, trapCause}, {29'd0, 1'b1, 2'(ex_cause)});
            chk({tag, "/trap_state"}, state, 6);
            haltReq = 1'b0;
            do_reset(1'b0);
        end else begin
            exp_count++;
            if (halt) begin
                @(posedge clk); #1;
                imemAck = 1'b0; dmemAck = 1'b0;
                @(negedge clk);
                chk({tag, "/halt_idle"}, state, 0);
                chk({tag, "/halt_count"}, instrCount, exp_count);
                haltReq = 1'b0;
            end
            exp_first = 1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        do_reset(1'b1);

        //          tag         op       m2r mw rw br     lk tk idel ddel halt
        run_instr("add",       4'b0000, 0,  0, 1, 2'b00, 0, 0, 0,   0,   0);
        run_instr("lw",        4'b0010, 1,  0, 1, 2'b00, 0, 0, 0,   3,   0);
        run_instr("bl",        4'b0100, 0,  0, 0, 2'b01, 1, 1, 0,   0,   0);
        run_instr("br",        4'b0100, 0,  0, 0, 2'b10, 0, 1, 2,   0,   0);
        run_instr("sw_halt",   4'b0010, 0,  1, 0, 2'b00, 0, 0, 1,   3,   1);
        run_instr("ack_edge",  4'b0010, 1,  0, 1, 2'b00, 0, 0, 15,  15,  0);
        run_instr("ill1010",   4'b1010, 0,  0, 1, 2'b00, 0, 0, 0,   0,   0);
        run_instr("ill_noctl", 4'b0011, 0,  0, 0, 2'b00, 0, 0, 0,   0,   0);
        run_instr("imem_to",   4'b0000, 0,  0, 1, 2'b00, 0, 0, 99,  0,   0);
        run_instr("dmem_to",   4'b0010, 0,  1, 0, 2'b00, 0, 0, 0,   99,  0);
        do_reset(1'b0);
        do_reset(1'b0);

        for (int n = 0; n < 40; n++) begin
            int idel, ddel;
            idel = ($urandom_range(0, 24) == 0) ? 99 : int'($urandom_range(0, 15));
            ddel = ($urandom_range(0, 24) == 0) ? 99 : int'($urandom_range(0, 15));
            run_instr($sformatf("rnd%0d", n), 4'($urandom_range(0, 5)),
                      1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                      1'($urandom), 1'($urandom), idel, ddel,
                      1'($urandom_range(0, 3) == 0));
        end

        @(posedge clk); #1;
        imemAck = 1'b0; dmemAck = 1'b0;
        @(negedge clk);
        chk("final_count", instrCount, exp_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
